mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               One shift-add (multiply) or restoring shift-subtract (divide)
//               step per cycle, with sign fix-up on the final cycle.
//               Define MDU_DIV_EN to include the divide datapath; without it
//               only MULTU/MULT are accepted and divide requests are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;

    // acc_hi: partial product / partial remainder
    // acc_lo: multiplier being consumed / dividend shifting into quotient
    // opnd  : multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;

    logic             go;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] ld_lo;
    logic [WIDTH-1:0] ld_opnd;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_r;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
`endif

    // Operand conditioning: magnitudes for signed ops, raw values otherwise
    always_comb begin
        a_neg = op[0] & A[WIDTH-1];
        b_neg = op[0] & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        ld_lo   = b_mag;
        ld_opnd = a_mag;
`ifdef MDU_DIV_EN
        go = start;
        if (op[1]) begin
            ld_lo   = a_mag;
            ld_opnd = b_mag;
        end
`else
        // Divide requests are dropped entirely when the divider is absent
        go = start & ~op[1];
`endif
    end

    // One iteration step and the final sign-corrected results
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod    = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When div_ge holds the true difference is below opnd, so W bits suffice
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
            if (opnd == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc_hi : acc_hi;
                res_lo = neg_q ? -acc_lo : acc_lo;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; busy covers every non-IDLE state
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (go) state_nxt = PREP;
            PREP: state_nxt = RUN;
            RUN:  if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, counter and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            a_raw  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        acc_hi <= '0;
                        acc_lo <= ld_lo;
                        opnd   <= ld_opnd;
                        neg_q  <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        is_div <= op[1];
                        neg_r  <= a_neg;
                        a_raw  <= A;
`endif
                    end else if (!start) begin
                        // start wins over MTHI/MTLO in the same cycle
                        if (we_hi) hi <= wdata;
                        if (we_lo) lo <= wdata;
                    end
                end
                PREP: cnt <= CW'(WIDTH - 1);
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

    // Completion pulse coincides with the HI/LO update on FIX exit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) done <= 1'b0;
        else        done <= (state == FIX);
    end

`ifdef MDU_DIV_EN
    // Divide-by-zero flag, valid only alongside done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_zero <= 1'b0;
        else        div_zero <= (state == FIX) && is_div && (opnd == '0);
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl (WIDTH=32) against a
//               plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = sa * sb;                 eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    edz = 1'b1; eh = a; el = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    p = q; el = p[31:0];
                    p = r; eh = p[31:0];
                end
            end
        endcase
    endfunction

    // Launch one operation and follow it to completion, checking timing and result
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          edges;
        int          bcyc;
        bit          dz_early;
        bit          hl_moved;
        model(o, a, b, eh, el, edz);
        @(negedge clk);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
        edges = 0; dz_early = 0; hl_moved = 0;
        bcyc = busy ? 1 : 0;
        while (!done && edges < 100) begin
            if (div_zero) dz_early = 1;
            if (hi !== hi0 || lo !== lo0) hl_moved = 1;
            if (disturb && edges == 10) begin
                start = 1'b1; we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h5A5A_5A5A;
            end else begin
                start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (busy) bcyc++;
        end
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        check("done_latency", 64'(edges), 64'd34);
        check("busy_cycles", 64'(bcyc), 64'd34);
        check("busy_low_at_done", {63'b0, busy}, 64'd0);
        check("hi", {32'b0, hi}, {32'b0, eh});
        check("lo", {32'b0, lo}, {32'b0, el});
        check("div_zero_at_done", {63'b0, div_zero}, {63'b0, edz});
        check("div_zero_early", {63'b0, dz_early}, 64'd0);
        check("hilo_stable_during_op", {63'b0, hl_moved}, 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("div_zero_after", {63'b0, div_zero}, 64'd0);
    endtask

    // A start that must be dropped: nothing moves
    task automatic ignored_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        check("ignored_done", {63'b0, done}, 64'd0);
        check("ignored_hi", {32'b0, hi}, {32'b0, hi0});
        check("ignored_lo", {32'b0, lo}, {32'b0, lo0});
    endtask

    initial begin
        logic [31:0] lo_keep;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          edges;
        bit          done_seen;

        reset = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_div_zero", {63'b0, div_zero}, 64'd0);
        reset = 1'b1;

        // Start in the first cycle after reset release
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
`ifdef MDU_DIV_EN
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b10, 32'd10, 32'd0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
`else
        ignored_start(2'b10, 32'd10, 32'd3);
        ignored_start(2'b11, 32'hFFFF_FFF9, 32'd2);
`endif

        // Second start and MT strobes mid-operation are ignored
        do_op(2'b01, 32'h0001_2345, 32'hFFFF_E000, 1'b1);

        // MTHI in IDLE
        @(negedge clk);
        lo_keep = lo;
        we_hi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        we_hi = 1'b0;
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'b0, lo}, {32'b0, lo_keep});

        // MTLO in IDLE
        @(negedge clk);
        we_lo = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        we_lo = 1'b0;
        check("mtlo_lo", {32'b0, lo}, 64'hCAFE_0001);
        check("mtlo_hi_kept", {32'b0, hi}, 64'h1234);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
`ifdef MDU_DIV_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            ra = $urandom;
            rb = (i % 5 == 4) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
            do_op(ro, ra, rb, 1'b0);
        end

        // Make HI/LO non-zero, then abort an operation at its 10th RUN cycle
        do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        reset = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
            if (k == 3) reset = 1'b1;
        end
        check("abort_no_done", {63'b0, done_seen}, 64'd0);
        check("abort_state_idle", {63'b0, busy}, 64'd0);

        // Fresh multiply after release
        do_op(2'b00, 32'd6, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
